// File: rtl/dsp_p_readback.sv
// Snapshots the P outputs of a DSP48E1 slice array on START and streams the
// snapshot out as OUT_WIDTH-bit beats over valid/ready, slice 0 first, LSB chunk first.
module dsp_p_readback #(
   parameter int G_SIZE    = 4,
   parameter int P_WIDTH   = 48,
   parameter int OUT_WIDTH = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        START,
   input  logic [G_SIZE*P_WIDTH-1:0]   P_IN,
   output logic [OUT_WIDTH-1:0]        OUT_DATA,
   output logic                        OUT_VALID,
   input  logic                        OUT_READY,
   output logic                        OUT_LAST,
   output logic                        BUSY,
   output logic                        DONE,
   output logic [OUT_WIDTH-1:0]        CHECKSUM
);

   localparam int CHUNKS  = P_WIDTH / OUT_WIDTH;
   localparam int SLICE_W = (G_SIZE > 1) ? $clog2(G_SIZE) : 1;
   localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(G_SIZE - 1);
   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, SNAP, SEND, FIN} state_t;

   state_t               state_p0;
   logic [OUT_WIDTH-1:0] shadow_p0 [G_SIZE][CHUNKS];
   logic [SLICE_W-1:0]   slice_p0;
   logic [CHUNK_W-1:0]   chunk_p0;
   logic [OUT_WIDTH-1:0] acc_p0;
   logic [OUT_WIDTH-1:0] checksum_p0;
   logic                 vld_p0;
   logic                 busy_p0;
   logic                 done_p0;
   logic [OUT_WIDTH-1:0] beat;
   logic                 last_beat;
   logic                 xfer;

   // Beat selection reads only registered state, so VALID never depends on READY.
   assign beat      = shadow_p0[slice_p0][chunk_p0];
   assign last_beat = (slice_p0 == LAST_SLICE) && (chunk_p0 == LAST_CHUNK);
   assign xfer      = vld_p0 && OUT_READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_p0 <= IDLE;
         for (int s = 0; s < G_SIZE; s++)
            for (int c = 0; c < CHUNKS; c++)
               shadow_p0[s][c] <= '0;
         slice_p0    <= '0;
         chunk_p0    <= '0;
         acc_p0      <= '0;
         checksum_p0 <= '0;
         vld_p0      <= 1'b0;
         busy_p0     <= 1'b0;
         done_p0     <= 1'b0;
      end else begin
         done_p0 <= 1'b0;
         case (state_p0)
            IDLE: begin
               // Snapshot is taken on the edge that leaves IDLE.
               if (START) begin
                  for (int s = 0; s < G_SIZE; s++)
                     for (int c = 0; c < CHUNKS; c++)
                        shadow_p0[s][c] <= P_IN[s*P_WIDTH + c*OUT_WIDTH +: OUT_WIDTH];
                  slice_p0 <= '0;
                  chunk_p0 <= '0;
                  acc_p0   <= '0;
                  busy_p0  <= 1'b1;
                  state_p0 <= SNAP;
               end
            end
            SNAP: begin
               vld_p0   <= 1'b1;
               state_p0 <= SEND;
            end
            SEND: begin
               if (xfer) begin
                  acc_p0 <= acc_p0 ^ beat;
                  if (chunk_p0 == LAST_CHUNK) begin
                     chunk_p0 <= '0;
                     slice_p0 <= (slice_p0 == LAST_SLICE) ? '0 : slice_p0 + 1'b1;
                  end else begin
                     chunk_p0 <= chunk_p0 + 1'b1;
                  end
                  if (last_beat) begin
                     vld_p0      <= 1'b0;
                     done_p0     <= 1'b1;
                     checksum_p0 <= acc_p0 ^ beat;
                     state_p0    <= FIN;
                  end
               end
            end
            FIN: begin
               busy_p0  <= 1'b0;
               state_p0 <= IDLE;
            end
            default: state_p0 <= IDLE;
         endcase
      end
   end

   assign OUT_DATA  = beat;
   assign OUT_VALID = vld_p0;
   assign OUT_LAST  = vld_p0 && last_beat;
   assign BUSY      = busy_p0;
   assign DONE      = done_p0;
   assign CHECKSUM  = checksum_p0;

endmodule

// File: tb/tb_dsp_p_readback.sv
// Directed bench for dsp_p_readback: readout order, backpressure, snapshot
// isolation, START filtering, mid-readout reset and continuous START.
module tb_dsp_p_readback;

   localparam int G  = 4;
   localparam int PW = 48;
   localparam int OW = 16;
   localparam int NB = 12;

   logic              CLK = 1'b0;
   logic              RST;
   logic              START;
   logic [G*PW-1:0]   P_IN;
   logic [OW-1:0]     OUT_DATA;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic              OUT_LAST;
   logic              BUSY;
   logic              DONE;
   logic [OW-1:0]     CHECKSUM;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   logic [OW-1:0] exp_b [NB];

   dsp_p_readback #(.G_SIZE(G), .P_WIDTH(PW), .OUT_WIDTH(OW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .P_IN(P_IN),
      .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_LAST(OUT_LAST), .BUSY(BUSY), .DONE(DONE), .CHECKSUM(CHECKSUM)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (DONE) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic set_pin(input logic [47:0] s0, s1, s2, s3);
      P_IN = {s3, s2, s1, s0};
   endtask

   task automatic set_exp(input logic [47:0] s0, s1, s2, s3);
      logic [47:0] s [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++)
            exp_b[i*3+j] = s[i][j*16 +: 16];
   endtask

   // Called at a negedge with the FSM in IDLE; returns at the first SEND negedge.
   task automatic start_rd();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("snap_busy", BUSY, 1);
      chk("snap_vld", OUT_VALID, 0);
      @(negedge CLK);
   endtask

   // mode 0: READY held 1; mode 1: READY 1,0,0 repeating over valid cycles.
   task automatic collect(input int mode, input int pulse_k, input int stop_k, input logic [OW-1:0] ck);
      int k = 0;
      int c = 0;
      int cyc = 0;
      while (k < NB && k != stop_k && cyc < 300) begin
         OUT_READY = (mode == 0) || (c % 3 == 0);
         START = (k == pulse_k);
         if (cyc == 0) chk("first_vld", OUT_VALID, 1);
         if (OUT_VALID) begin
            chk($sformatf("beat%0d", k), OUT_DATA, exp_b[k]);
            chk($sformatf("last%0d", k), OUT_LAST, (k == NB-1));
            if (OUT_READY) k++;
            c++;
         end
         cyc++;
         @(negedge CLK);
      end
      START = 1'b0;
      OUT_READY = 1'b1;
      if (k == stop_k) return;
      if (k < NB) begin
         chk("timeout_beats", k, NB);
         return;
      end
      chk("done", DONE, 1);
      chk("fin_vld", OUT_VALID, 0);
      chk("fin_busy", BUSY, 1);
      chk("cksum", CHECKSUM, ck);
      @(negedge CLK);
      chk("done_pulse", DONE, 0);
      chk("idle_busy", BUSY, 0);
   endtask

   initial begin
      int d0, first_done, gap, rises;
      logic prev_v;

      RST = 1'b1; START = 1'b0; OUT_READY = 1'b0; P_IN = '0;
      repeat (3) @(negedge CLK);
      chk("rst_vld", OUT_VALID, 0);
      chk("rst_data", OUT_DATA, 0);
      chk("rst_last", OUT_LAST, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_cksum", CHECKSUM, 0);
      RST = 1'b0;
      OUT_READY = 1'b1;
      @(negedge CLK);
      chk("idle_vld", OUT_VALID, 0);

      // basic readout
      set_pin(48'h0000_1111_2222, 48'h0000_1111_2223, 48'h0000_1111_2224, 48'h0000_1111_2225);
      set_exp(48'h0000_1111_2222, 48'h0000_1111_2223, 48'h0000_1111_2224, 48'h0000_1111_2225);
      start_rd();
      collect(0, -1, -1, 16'h0000);

      // checksum with distinct first and last slices
      set_pin(48'h1234_5678_9ABC, 48'h0, 48'h0, 48'h8000_0000_000F);
      set_exp(48'h1234_5678_9ABC, 48'h0, 48'h0, 48'h8000_0000_000F);
      start_rd();
      collect(0, -1, -1, 16'h5EFF);
      repeat (3) @(negedge CLK);
      chk("cksum_hold", CHECKSUM, 16'h5EFF);

      // reset in the middle of a readout
      set_pin(48'h0000_1111_2222, 48'h0000_1111_2223, 48'h0000_1111_2224, 48'h0000_1111_2225);
      set_exp(48'h0000_1111_2222, 48'h0000_1111_2223, 48'h0000_1111_2224, 48'h0000_1111_2225);
      start_rd();
      collect(0, -1, 7, 16'h0000);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mrst_vld", OUT_VALID, 0);
      chk("mrst_data", OUT_DATA, 0);
      chk("mrst_last", OUT_LAST, 0);
      chk("mrst_busy", BUSY, 0);
      chk("mrst_done", DONE, 0);
      chk("mrst_cksum", CHECKSUM, 0);
      @(negedge CLK);
      chk("mrst_idle", OUT_VALID, 0);
      start_rd();
      collect(0, -1, -1, 16'h0000);

      // backpressure
      set_pin(48'hAAAA_5555_FFFF, 48'hAAAA_5555_FFFF, 48'hAAAA_5555_FFFF, 48'hAAAA_5555_FFFF);
      set_exp(48'hAAAA_5555_FFFF, 48'hAAAA_5555_FFFF, 48'hAAAA_5555_FFFF, 48'hAAAA_5555_FFFF);
      start_rd();
      collect(1, -1, -1, 16'h0000);

      // snapshot isolation
      set_pin(48'h1, 48'h1, 48'h1, 48'h1);
      set_exp(48'h1, 48'h1, 48'h1, 48'h1);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      set_pin(48'h2, 48'h2, 48'h2, 48'h2);
      @(negedge CLK);
      collect(0, -1, -1, 16'h0000);

      // START during beat 5 is ignored
      set_pin(48'h0000_1111_2222, 48'h0000_1111_2223, 48'h0000_1111_2224, 48'h0000_1111_2225);
      set_exp(48'h0000_1111_2222, 48'h0000_1111_2223, 48'h0000_1111_2224, 48'h0000_1111_2225);
      d0 = done_cnt;
      start_rd();
      collect(0, 5, -1, 16'h0000);
      repeat (20) @(negedge CLK);
      chk("one_done", done_cnt - d0, 1);
      chk("no_rerun_busy", BUSY, 0);
      chk("no_rerun_vld", OUT_VALID, 0);

      // START held high
      d0 = done_cnt;
      first_done = -1;
      gap = -1;
      rises = 0;
      prev_v = 1'b0;
      START = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (DONE && first_done < 0) first_done = i;
         if (OUT_VALID && !prev_v) begin
            rises++;
            if (first_done >= 0 && gap < 0) gap = i - first_done;
         end
         prev_v = OUT_VALID;
         @(negedge CLK);
      end
      START = 1'b0;
      chk("cont_dones", done_cnt - d0, 2);
      chk("cont_rises", rises, 3);
      chk("restart_gap", gap, 3);
      repeat (20) @(negedge CLK);
      chk("cont_end_busy", BUSY, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
